// File: rtl/led_mode_blinker.sv
// Per-channel LED driver with run-time mode selection and a blink FSM for short triggers.
// A global lamp-test mode overrides all channels with a walking one.
module led_mode_blinker #(
    parameter int LEDS         = 6,
    parameter int PHASE_CYCLES = 4194304
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LEDS-1:0]     triggers,
    input  logic [LEDS-1:0]     levels,
    input  logic [2*LEDS-1:0]   mode,
    input  logic                test_mode,
    output logic [LEDS-1:0]     out
);

    localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int IW = (LEDS > 1) ? $clog2(LEDS) : 1;

    localparam logic [CW-1:0] CNT_RELOAD = CW'(PHASE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(LEDS - 1);
    localparam logic [IW-1:0] IDX_ZERO   = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE    = IW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } blink_state_t;

    blink_state_t    state_r      [LEDS];
    blink_state_t    state_next_s [LEDS];
    logic [CW-1:0]   cnt_r        [LEDS];
    logic [CW-1:0]   cnt_next_s   [LEDS];
    logic [LEDS-1:0] pending_r;
    logic [LEDS-1:0] pending_next_s;
    logic [LEDS-1:0] out_r;
    logic [LEDS-1:0] out_next_s;

    logic            test_q_r;
    logic [IW-1:0]   test_idx_r;
    logic [IW-1:0]   test_idx_next_s;
    logic [CW-1:0]   test_cnt_r;
    logic [CW-1:0]   test_cnt_next_s;

    function automatic logic [1:0] chan_mode(input logic [2*LEDS-1:0] m, input int ch);
        return m[2*ch +: 2];
    endfunction

    // State register: channel FSMs, lamp-test sequencer and the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEDS; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= CNT_ZERO;
            end
            pending_r  <= {LEDS{1'b0}};
            out_r      <= {LEDS{1'b0}};
            test_q_r   <= 1'b0;
            test_idx_r <= IDX_ZERO;
            test_cnt_r <= CNT_ZERO;
        end else begin
            for (int i = 0; i < LEDS; i++) begin
                state_r[i] <= state_next_s[i];
                cnt_r[i]   <= cnt_next_s[i];
            end
            pending_r  <= pending_next_s;
            out_r      <= out_next_s;
            test_q_r   <= test_mode;
            test_idx_r <= test_idx_next_s;
            test_cnt_r <= test_cnt_next_s;
        end
    end

    // Next-state logic for the channel blink FSMs; mode 0 pins a channel to IDLE
    always_comb begin
        pending_next_s = pending_r;
        for (int i = 0; i < LEDS; i++) begin
            state_next_s[i] = state_r[i];
            cnt_next_s[i]   = cnt_r[i];
            if (chan_mode(mode, i) == 2'd0) begin
                state_next_s[i]   = ST_IDLE;
                cnt_next_s[i]     = CNT_ZERO;
                pending_next_s[i] = 1'b0;
            end else begin
                case (state_r[i])
                    ST_IDLE: begin
                        pending_next_s[i] = 1'b0;
                        if (triggers[i]) begin
                            state_next_s[i] = ST_ON;
                            cnt_next_s[i]   = CNT_RELOAD;
                        end else begin
                            cnt_next_s[i]   = CNT_ZERO;
                        end
                    end
                    ST_ON: begin
                        pending_next_s[i] = pending_r[i] | triggers[i];
                        if (cnt_r[i] == CNT_ZERO) begin
                            state_next_s[i] = ST_OFF;
                            cnt_next_s[i]   = CNT_RELOAD;
                        end else begin
                            cnt_next_s[i]   = cnt_r[i] - CNT_ONE;
                        end
                    end
                    ST_OFF: begin
                        if (cnt_r[i] == CNT_ZERO) begin
                            pending_next_s[i] = 1'b0;
                            // A trigger landing on the last OFF cycle goes straight back to ON
                            if (pending_r[i] || triggers[i]) begin
                                state_next_s[i] = ST_ON;
                                cnt_next_s[i]   = CNT_RELOAD;
                            end else begin
                                state_next_s[i] = ST_IDLE;
                                cnt_next_s[i]   = CNT_ZERO;
                            end
                        end else begin
                            pending_next_s[i] = pending_r[i] | triggers[i];
                            cnt_next_s[i]     = cnt_r[i] - CNT_ONE;
                        end
                    end
                    default: begin
                        state_next_s[i]   = ST_IDLE;
                        cnt_next_s[i]     = CNT_ZERO;
                        pending_next_s[i] = 1'b0;
                    end
                endcase
            end
        end
    end

    // Lamp-test sequencer: restarts on a rising test_mode, steps once per phase
    always_comb begin
        test_idx_next_s = test_idx_r;
        test_cnt_next_s = test_cnt_r;
        if (test_mode && !test_q_r) begin
            test_idx_next_s = IDX_ZERO;
            test_cnt_next_s = CNT_ZERO;
        end else if (test_mode) begin
            if (test_cnt_r == CNT_RELOAD) begin
                test_cnt_next_s = CNT_ZERO;
                if (test_idx_r == IDX_LAST) begin
                    test_idx_next_s = IDX_ZERO;
                end else begin
                    test_idx_next_s = test_idx_r + IDX_ONE;
                end
            end else begin
                test_cnt_next_s = test_cnt_r + CNT_ONE;
            end
        end else begin
            test_idx_next_s = test_idx_r;
            test_cnt_next_s = test_cnt_r;
        end
    end

    // Output decode from next-state so a trigger shows up right after its sampling edge
    always_comb begin
        out_next_s = {LEDS{1'b0}};
        for (int i = 0; i < LEDS; i++) begin
            if (test_mode) begin
                out_next_s[i] = (test_idx_next_s == IW'(i));
            end else begin
                case (chan_mode(mode, i))
                    2'd0:    out_next_s[i] = 1'b0;
                    2'd1:    out_next_s[i] = (state_next_s[i] == ST_ON);
                    2'd2:    out_next_s[i] = levels[i];
                    2'd3:    out_next_s[i] = levels[i] & (state_next_s[i] != ST_ON);
                    default: out_next_s[i] = 1'b0;
                endcase
            end
        end
    end

    assign out = out_r;

endmodule

// File: tb/tb_led_mode_blinker.sv
// Bench for led_mode_blinker: timeline-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_led_mode_blinker;

    localparam int LEDS = 6;
    localparam int P    = 4;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic [LEDS-1:0]   triggers  = '0;
    logic [LEDS-1:0]   levels    = '0;
    logic [2*LEDS-1:0] mode      = '0;
    logic              test_mode = 1'b0;
    logic [LEDS-1:0]   out;

    int vectors     = 0;
    int miscompares = 0;

    led_mode_blinker #(.LEDS(LEDS), .PHASE_CYCLES(P)) dut (
        .clk(clk), .rst_n(rst_n), .triggers(triggers), .levels(levels),
        .mode(mode), .test_mode(test_mode), .out(out)
    );

    always #5 clk = ~clk;

    // Reference model: each blink is a start edge; ON covers ages 0..P-1, OFF ages P..2P-1,
    // and at age 2P a new blink starts if any trigger arrived after the start.
    int              ecount = 0;
    int              start_e [LEDS] = '{default: -1};
    bit              got     [LEDS] = '{default: 1'b0};
    bit              prev_tm = 1'b0;
    int              tstart  = 0;
    logic [LEDS-1:0] exp_out = '0;
    logic [1:0]      m_md;
    int              m_age;
    bit              m_on;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecount = 0;
            for (int i = 0; i < LEDS; i++) begin
                start_e[i] = -1;
                got[i]     = 1'b0;
            end
            prev_tm = 1'b0;
            tstart  = 0;
            exp_out = '0;
        end else begin
            ecount++;
            for (int i = 0; i < LEDS; i++) begin
                m_md = mode[2*i +: 2];
                if (m_md == 2'd0) begin
                    start_e[i] = -1;
                    got[i]     = 1'b0;
                end else if (start_e[i] < 0) begin
                    if (triggers[i]) start_e[i] = ecount;
                end else begin
                    m_age = ecount - start_e[i];
                    if (m_age >= 2*P) begin
                        start_e[i] = (got[i] || triggers[i]) ? ecount : -1;
                        got[i]     = 1'b0;
                    end else if (triggers[i]) begin
                        got[i] = 1'b1;
                    end
                end
                m_on = (start_e[i] >= 0) && ((ecount - start_e[i]) < P);
                case (m_md)
                    2'd1:    exp_out[i] = m_on;
                    2'd2:    exp_out[i] = levels[i];
                    2'd3:    exp_out[i] = levels[i] & ~m_on;
                    default: exp_out[i] = 1'b0;
                endcase
            end
            if (test_mode && !prev_tm) tstart = ecount;
            prev_tm = test_mode;
            if (test_mode) begin
                exp_out = '0;
                exp_out[((ecount - tstart) / P) % LEDS] = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        vectors++;
        if (out !== exp_out) begin
            miscompares++;
            $display("FAIL cycle_check edge=%0d out=%b expected=%b", ecount, out, exp_out);
        end
    end

    task automatic chk(input string name, input logic [LEDS-1:0] got_v, input logic [LEDS-1:0] want);
        vectors++;
        if (got_v !== want) begin
            miscompares++;
            $display("FAIL %s edge=%0d got=%b want=%b", name, ecount, got_v, want);
        end
    endtask

    task automatic goto(input int k);
        while (ecount < k) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    int b;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_out", out, 6'b000000);
        // ch0 act, ch1 link/act, ch2 act, ch3 level, ch4/ch5 off
        mode  = {2'd0, 2'd0, 2'd2, 2'd1, 2'd3, 2'd1};
        rst_n = 1'b1;

        // single 1-cycle trigger at edge 10
        goto(9);  triggers[0] = 1'b1;
        goto(10); triggers[0] = 1'b0; chk("s1_on_first", {5'b0, out[0]}, 6'd1);
        goto(13); chk("s1_on_last",  {5'b0, out[0]}, 6'd1);
        goto(14); chk("s1_off_first", {5'b0, out[0]}, 6'd0);
        goto(20); chk("s1_idle", {5'b0, out[0]}, 6'd0);

        // triggers at b+10, b+11, b+15 -> exactly two blinks
        b = 30;
        goto(b+9);  triggers[0] = 1'b1;
        goto(b+11); triggers[0] = 1'b0;
        goto(b+13); chk("s2_on_last", {5'b0, out[0]}, 6'd1);
        goto(b+14); triggers[0] = 1'b1; chk("s2_off", {5'b0, out[0]}, 6'd0);
        goto(b+15); triggers[0] = 1'b0;
        goto(b+17); chk("s2_off_last", {5'b0, out[0]}, 6'd0);
        goto(b+18); chk("s2_second_on", {5'b0, out[0]}, 6'd1);
        goto(b+21); chk("s2_second_last", {5'b0, out[0]}, 6'd1);
        goto(b+22); chk("s2_second_off", {5'b0, out[0]}, 6'd0);
        goto(b+35); chk("s2_no_third", {5'b0, out[0]}, 6'd0);

        // link/act on ch1
        b = 70;
        goto(b+10); levels[1] = 1'b1;
        goto(b+19); chk("s3_link_before", {5'b0, out[1]}, 6'd1); triggers[1] = 1'b1;
        goto(b+20); triggers[1] = 1'b0; chk("s3_blink_off", {5'b0, out[1]}, 6'd0);
        goto(b+23); chk("s3_blink_off_last", {5'b0, out[1]}, 6'd0);
        goto(b+24); chk("s3_link_back", {5'b0, out[1]}, 6'd1);
        goto(b+30); levels[1] = 1'b0;
        goto(b+39); triggers[1] = 1'b1;
        goto(b+40); triggers[1] = 1'b0; chk("s3_nolink_a", {5'b0, out[1]}, 6'd0);
        goto(b+44); chk("s3_nolink_b", {5'b0, out[1]}, 6'd0);
        goto(b+45); chk("s3_level_low", {5'b0, out[3]}, 6'd0); levels[3] = 1'b1;
        goto(b+46); chk("s3_level_high", {5'b0, out[3]}, 6'd1);

        // mode 0 aborts an in-flight blink on ch2
        b = 120;
        goto(b+9);  triggers[2] = 1'b1;
        goto(b+10); triggers[2] = 1'b0;
        goto(b+11); chk("s4_on", {5'b0, out[2]}, 6'd1); mode[5:4] = 2'd0;
        goto(b+12); chk("s4_abort", {5'b0, out[2]}, 6'd0); mode[5:4] = 2'd1;
        goto(b+20); chk("s4_stay_idle", {5'b0, out[2]}, 6'd0);
        goto(b+25); triggers[2] = 1'b1; mode[5:4] = 2'd0;
        goto(b+26); triggers[2] = 1'b0; mode[5:4] = 2'd1;
        goto(b+27); chk("s4_idle_wins", {5'b0, out[2]}, 6'd0);

        // lamp test
        b = 160;
        goto(b+4);  test_mode = 1'b1;
        goto(b+5);  chk("t_idx0_first", out, 6'b000001);
        goto(b+8);  chk("t_idx0_last",  out, 6'b000001);
        goto(b+9);  chk("t_idx1",       out, 6'b000010);
        goto(b+28); chk("t_idx5",       out, 6'b100000);
        goto(b+29); chk("t_wrap",       out, 6'b000001);
        goto(b+30); test_mode = 1'b0;
        goto(b+31); chk("t_exit", out, 6'b001000);

        // async reset mid-ON
        b = 200;
        goto(b+9);  triggers[0] = 1'b1;
        goto(b+10); triggers[0] = 1'b0;
        goto(b+11); chk("r_pre_on", {5'b0, out[0]}, 6'd1);
        #2 rst_n = 1'b0;
        #1 chk("r_async_on", out, 6'b000000);
        @(negedge clk); rst_n = 1'b1; test_mode = 1'b1;
        goto(2); chk("r_test_on", out, 6'b000001);
        #2 rst_n = 1'b0;
        #1 chk("r_async_test", out, 6'b000000);
        @(negedge clk); rst_n = 1'b1; test_mode = 1'b0;
        goto(4); triggers[0] = 1'b1;
        goto(5); triggers[0] = 1'b0; chk("r_blink_first", {5'b0, out[0]}, 6'd1);
        goto(8); chk("r_blink_last", {5'b0, out[0]}, 6'd1);
        goto(9); chk("r_blink_end", {5'b0, out[0]}, 6'd0);

        // mixed traffic checked by the model only
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            triggers = LEDS'($urandom) & LEDS'($urandom) & LEDS'($urandom);
            if (c % 9 == 0) levels = LEDS'($urandom);
            if (c % 37 == 0) mode = (2*LEDS)'($urandom);
            if (c % 61 == 0) test_mode = ($urandom_range(0, 3) == 0);
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
